// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline: widths, canonical NOP and fetch FSM encoding.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int OPC_W = 7;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // Sequential-PC step; wraps at 2^32 by construction of the 32-bit sum.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_stage_if;

  logic                    imem_req;
  logic [rv_pkg::XLEN-1:0] imem_addr;
  logic                    imem_ready;
  logic                    imem_rvalid;
  logic [rv_pkg::XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_hold_buf.sv
// One-entry inst/pc buffer parking an imem response that lands while decode is stalled.
module fetch_hold_buf
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] load_inst,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);

  // Clear wins over load: a redirect drops the entry even if a load is requested.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding imem request, redirect flush, IF/ID register.
//   state | meaning
//   REQ   | issue a request for pc when imem is ready
//   WAIT  | request accepted, waiting for rvalid (kill marks it stale)
//   HOLD  | response parked in fetch_hold_buf until decode unstalls
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  fetch_stage_if.master    imem,
  output logic             o_id_valid,
  output logic [XLEN-1:0]  o_id_inst,
  output logic [XLEN-1:0]  o_id_pc,
  output logic [XLEN-1:0]  o_id_pc4,
  output logic [OPC_W-1:0] o_id_opcode
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            kill;

  logic            hold_valid;
  logic [XLEN-1:0] hold_inst;
  logic [XLEN-1:0] hold_pc;

  logic [XLEN-1:0] redirect_tgt;
  logic            fire;
  logic            rsp_accept;
  logic            wait_load;
  logic            hold_load;
  logic            hold_rel;
  logic            hold_clear;
  logic            unused_redirect_lsbs;

  assign redirect_tgt         = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  assign imem.imem_req  = (state == REQ) & ~i_redirect & ~i_rst;
  assign imem.imem_addr = pc;

  assign fire       = imem.imem_req & imem.imem_ready;
  assign rsp_accept = (state == WAIT) & imem.imem_rvalid & ~kill & ~i_redirect;
  assign wait_load  = rsp_accept & ~i_stall;
  assign hold_load  = rsp_accept & i_stall;
  assign hold_rel   = (state == HOLD) & hold_valid & ~i_stall & ~i_redirect;
  assign hold_clear = ((state == HOLD) & i_redirect) | hold_rel;

  assign o_id_opcode = o_id_inst[OPC_W-1:0];

  fetch_hold_buf u_hold_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_inst (imem.imem_rdata),
    .load_pc   (req_pc),
    .valid     (hold_valid),
    .inst      (hold_inst),
    .pc        (hold_pc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= REQ;
      pc         <= RESET_ADDR;
      req_pc     <= '0;
      kill       <= 1'b0;
      o_id_valid <= 1'b0;
      o_id_inst  <= NOP_INST;
      o_id_pc    <= '0;
      o_id_pc4   <= 32'd4;
    end else begin
      case (state)
        REQ: begin
          if (fire) begin
            req_pc <= pc;
            pc     <= pc_plus4(pc);
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            // Stale or redirected responses drain here; only a live stalled one parks.
            kill <= 1'b0;
            if (i_redirect || kill || !i_stall) state <= REQ;
            else                                state <= HOLD;
          end else if (i_redirect) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (i_redirect || hold_rel) state <= REQ;
        end
        default: state <= REQ;
      endcase

      if (i_redirect) pc <= redirect_tgt;

      if (i_redirect) begin
        o_id_valid <= 1'b0;
      end else if (!i_stall) begin
        if (wait_load) begin
          o_id_valid <= 1'b1;
          o_id_inst  <= imem.imem_rdata;
          o_id_pc    <= req_pc;
          o_id_pc4   <= pc_plus4(req_pc);
        end else if (hold_rel) begin
          o_id_valid <= 1'b1;
          o_id_inst  <= hold_inst;
          o_id_pc    <= hold_pc;
          o_id_pc4   <= pc_plus4(hold_pc);
        end else begin
          o_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-accurate directed vectors for fetch_stage plus a PC-wrap sequence on a second instance.
module tb_fetch_stage;
  import rv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redir;
  logic [31:0] rpc;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic [6:0]  id_opc;
  fetch_stage_if imem ();

  fetch_stage #(.RESET_ADDR(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_redirect(redir), .i_redirect_pc(rpc),
    .imem(imem), .o_id_valid(id_valid), .o_id_inst(id_inst), .o_id_pc(id_pc),
    .o_id_pc4(id_pc4), .o_id_opcode(id_opc)
  );

  logic        b_rst, b_stall, b_redir;
  logic [31:0] b_rpc;
  logic        b_valid;
  logic [31:0] b_inst, b_pc, b_pc4;
  logic [6:0]  b_opc;
  fetch_stage_if imem_b ();

  fetch_stage #(.RESET_ADDR(32'hFFFF_FFFC)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_stall(b_stall), .i_redirect(b_redir), .i_redirect_pc(b_rpc),
    .imem(imem_b), .o_id_valid(b_valid), .o_id_inst(b_inst), .o_id_pc(b_pc),
    .o_id_pc4(b_pc4), .o_id_opcode(b_opc)
  );

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        id_chk;
    logic [31:0] inst, pc, pc4;
  } vec_t;

  vec_t tv[$];
  int   n_pass  = 0;
  int   n_total = 0;

  localparam logic [31:0] I1 = 32'h0010_0093, I2 = 32'h0020_8113, I3 = 32'h0050_0093;
  localparam logic [31:0] I4 = 32'hDEAD_BEEF, I5 = 32'h0000_0297, I6 = 32'h0FF0_0713;
  localparam logic [31:0] I7 = 32'h00C0_0513, I8 = 32'h00A0_0593;

  function automatic void add(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                              input logic rdy, input logic rv, input logic [31:0] rdat,
                              input logic q, input logic [31:0] a, input logic v, input logic c,
                              input logic [31:0] ins, input logic [31:0] p, input logic [31:0] p4);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.rpc = rp; t.ready = rdy; t.rvalid = rv; t.rdata = rdat;
    t.req = q; t.addr = a; t.vld = v; t.id_chk = c; t.inst = ins; t.pc = p; t.pc4 = p4;
    tv.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0;
    imem.imem_ready = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    b_rst = 1'b1; b_stall = 1'b0; b_redir = 1'b0; b_rpc = '0;
    imem_b.imem_ready = 1'b0; imem_b.imem_rvalid = 1'b0; imem_b.imem_rdata = '0;

    //  rst st rd rpc         rdy rv rdata | req addr         vld chk inst      pc          pc4
    add(1, 0, 0, 32'h0,       0, 0, 32'h0, 0, 32'h0,       0, 1, NOP_INST, 32'h0,   32'h4);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'h0,       0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 1, I1,    0, 32'h4,       0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'h4,       1, 1, I1,       32'h0,   32'h4);
    add(0, 0, 0, 32'h0,       1, 1, I2,    0, 32'h8,       0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 1, 0, 32'h0,       1, 0, 32'h0, 1, 32'h8,       1, 1, I2,       32'h4,   32'h8);
    add(0, 1, 0, 32'h0,       1, 1, I3,    0, 32'hC,       1, 1, I2,       32'h4,   32'h8);
    add(0, 1, 0, 32'h0,       1, 0, 32'h0, 0, 32'hC,       1, 1, I2,       32'h4,   32'h8);
    add(0, 1, 0, 32'h0,       1, 0, 32'h0, 0, 32'hC,       1, 1, I2,       32'h4,   32'h8);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 0, 32'hC,       1, 1, I2,       32'h4,   32'h8);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'hC,       1, 1, I3,       32'h8,   32'hC);
    add(0, 0, 1, 32'h100,     1, 0, 32'h0, 0, 32'h10,      0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 1, I4,    0, 32'h100,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'h100,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 1, I5,    0, 32'h104,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 1, 1, 32'h1F0,     1, 0, 32'h0, 0, 32'h104,     1, 1, I5,       32'h100, 32'h104);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'h1F0,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 1, 32'h203,     1, 1, I6,    0, 32'h1F4,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0, 1, 32'h200,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'h200,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 1, I7,    0, 32'h204,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0, 1, 32'h204,     1, 1, I7,       32'h200, 32'h204);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'h204,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 1, 0, 32'h0,       1, 1, I8,    0, 32'h208,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 1, 1, 32'h40,      1, 0, 32'h0, 0, 32'h208,     0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       0, 0, 32'h0, 1, 32'h40,      0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 0, 0, 32'h0,       1, 0, 32'h0, 1, 32'h40,      0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 1, 0, 32'h0,       1, 0, 32'h0, 0, 32'h44,      0, 0, 32'h0,    32'h0,   32'h0);
    add(1, 1, 0, 32'h0,       1, 0, 32'h0, 0, 32'h44,      0, 0, 32'h0,    32'h0,   32'h0);
    add(0, 1, 0, 32'h0,       0, 0, 32'h0, 1, 32'h0,       0, 1, NOP_INST, 32'h0,   32'h4);

    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; stall = tv[i].stall; redir = tv[i].redir; rpc = tv[i].rpc;
      imem.imem_ready = tv[i].ready; imem.imem_rvalid = tv[i].rvalid; imem.imem_rdata = tv[i].rdata;
      #1;
      chk("imem_req", i, {31'b0, imem.imem_req}, {31'b0, tv[i].req});
      chk("imem_addr", i, imem.imem_addr, tv[i].addr);
      chk("id_valid", i, {31'b0, id_valid}, {31'b0, tv[i].vld});
      if (tv[i].id_chk) begin
        chk("id_inst", i, id_inst, tv[i].inst);
        chk("id_pc", i, id_pc, tv[i].pc);
        chk("id_pc4", i, id_pc4, tv[i].pc4);
        chk("id_opcode", i, {25'b0, id_opc}, {25'b0, tv[i].inst[6:0]});
      end
    end

    // PC wrap from RESET_ADDR = 0xFFFF_FFFC
    @(negedge clk);
    b_rst = 1'b0; imem_b.imem_ready = 1'b1;
    #1;
    chk("wrap_req0", 0, {31'b0, imem_b.imem_req}, 32'd1);
    chk("wrap_addr0", 0, imem_b.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_b.imem_ready = 1'b0; imem_b.imem_rvalid = 1'b1; imem_b.imem_rdata = I1;
    #1;
    chk("wrap_req1", 1, {31'b0, imem_b.imem_req}, 32'd0);
    chk("wrap_addr1", 1, imem_b.imem_addr, 32'h0);
    @(negedge clk);
    imem_b.imem_ready = 1'b1; imem_b.imem_rvalid = 1'b0;
    #1;
    chk("wrap_req2", 2, {31'b0, imem_b.imem_req}, 32'd1);
    chk("wrap_addr2", 2, imem_b.imem_addr, 32'h0);
    chk("wrap_valid", 2, {31'b0, b_valid}, 32'd1);
    chk("wrap_inst", 2, b_inst, I1);
    chk("wrap_pc", 2, b_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", 2, b_pc4, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Holds the PC, issues one instruction-memory request at a time and accepts redirects from branch/jump resolution. Buffers the returned word across decode stalls and drives the IF/ID register consumed by `control_decode` and the rest of decode. At most one imem request is outstanding.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: PC value after reset; must be 4-byte aligned.
- `i_clk` in 1: core clock; all state updates on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_stall` in 1: decode hazard hold; IF/ID keeps its contents.
- `i_redirect` in 1: taken branch/JAL/JALR; flush and refetch.
- `i_redirect_pc` in 32: redirect target; bits [1:0] ignored (treated as 0).
- `o_imem_req` out 1: fetch request valid.
- `o_imem_addr` out 32: fetch address (word aligned).
- `i_imem_ready` in 1: imem accepts the request this cycle.
- `i_imem_rvalid` in 1: response valid; no backpressure, at most one per accepted request.
- `i_imem_rdata` in 32: instruction word.
- `o_id_valid` out 1: IF/ID holds a live instruction.
- `o_id_inst` out 32: IF/ID instruction.
- `o_id_pc` out 32: PC of `o_id_inst`.
- `o_id_pc4` out 32: `o_id_pc + 4` (mod 2^32), registered.
- `o_id_opcode` out 7: `o_id_inst[6:0]`, combinational; drives decode `i_opcode`.

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_pc`: address of the outstanding request.
  - `kill`: the outstanding response is stale.
  - `hold_inst`/`hold_pc`: buffer for a response that arrives during a stall.
  - IF/ID fields.
  - 2-bit FSM: REQ, WAIT, HOLD.
- `o_imem_req = (state==REQ) & !i_redirect`. `o_imem_addr = pc`.
- REQ: on `o_imem_req & i_imem_ready`, set `req_pc<=pc`, `pc<=pc+4`, go to WAIT.
- WAIT, on `i_imem_rvalid`:
  - `kill`=1: discard the word, clear `kill`, go to REQ.
  - `!i_stall`: load IF/ID with {1, rdata, req_pc, req_pc+4}, go to REQ.
  - `i_stall`: capture into `hold_*`, go to HOLD.
- HOLD: when `!i_stall`, move `hold_*` into IF/ID, go to REQ.
- IF/ID update priority, highest first:
  1. Redirect: `o_id_valid<=0`.
  2. Stall: hold contents.
  3. Load, as defined above.
  4. Otherwise `o_id_valid<=0` (bubble); inst/pc fields may keep old values.
- Redirect (any state, overrides stall):
  - `pc <= {i_redirect_pc[31:2],2'b00}`.
  - REQ: no request issued that cycle; stay in REQ.
  - WAIT: set `kill`, stay in WAIT. If `rvalid` arrives in the same cycle, discard it, leave `kill` clear, go to REQ.
  - HOLD: drop the buffer, go to REQ.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 32'h0.
- Reset values:
  - `pc=RESET_ADDR`, state REQ, `kill=0`.
  - `o_id_valid=0`, `o_id_inst=32'h0000_0013` (NOP), `o_id_pc=0`, `o_id_pc4=4`.
  - `hold_*` = 0.
  - `o_imem_req` forced 0 while `i_rst`=1.
- Reset mid-request: the outstanding request is abandoned. `kill` is not set, so the imem side must also be reset by `i_rst`.

## Timing
- Request accepted in cycle N, `rvalid` in cycle N+k (k≥1): `o_id_valid` is high from cycle N+k+1 if not stalled.
- Next request can issue no earlier than cycle N+k+1. Peak throughput is one instruction per 2 cycles with k=1.
- Redirect in cycle N: IF/ID is invalid in N+1. The first request to the target issues in N+1 if state is REQ, otherwise after the stale response drains.
- A response during a stall is never lost; HOLD releases it the first unstalled cycle.

## Structure
- Shared package `rv_pkg`:
  - `NOP_INST` = 32'h0000_0013.
  - `XLEN` = 32.
  - `OPC_W` = 7.
  - fetch FSM state enum (REQ/WAIT/HOLD).
- One sub-module, `fetch_hold_buf`: a one-entry inst/pc buffer with load/clear/valid. The FSM, PC and IF/ID registers stay in `fetch_stage`.

## Test plan
- Reset, imem ready=1, response latency 1 → requests at 0x0, 0x4, 0x8 every 2 cycles. IF/ID shows pc 0x0/inst as returned, `o_id_pc4`=0x4. `o_id_opcode` equals `inst[6:0]`.
- Response 0x00500093 arrives while `i_stall`=1 for 3 cycles → state HOLD. IF/ID unchanged, no new request. On release, IF/ID = {1, 0x00500093, req_pc}.
- Redirect to 0x100 while WAIT → stale response discarded, IF/ID invalid next cycle, next request address 0x100.
- Redirect to 0x203 in the same cycle as `rvalid` → word dropped, next request 0x200, no IF/ID load.
- `RESET_ADDR`=0xFFFF_FFFC → first fetch 0xFFFF_FFFC, second 0x0, `o_id_pc4`=0x0.
- `i_rst` asserted during WAIT with `i_stall`=1 → next cycle all outputs at reset values, `o_imem_req`=1 to `RESET_ADDR`.
